pc_next_ctrl: RTL and testbench

- Registered next-PC controller for the fetch stage of the 16-bit pipelined RISC core.
- Holds the fetch PC and decodes control-transfer instructions in decode: branch, J, JAL, JR, JALR and HALT.
- Computes the target, redirects fetch, squashes one wrong-path slot and produces the link write for JAL/JALR.
- Parametrised successor to the combinational jump-base select: adds PC width, displacement scaling, a squash FSM, stall handling and halt.

---
 rtl/pc_next_ctrl.sv | 134 +++++++++++++
 tb/tb_pc_next_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_ctrl
// Purpose  : Registered fetch PC with decode-stage control-transfer resolution,
//            one-slot wrong-path squash, JAL/JALR link write and sticky halt.
//            Optional target alignment check enabled by PC_ALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_ctrl #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              BR_SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            dec_valid,
    input  logic [15:0]     dec_instr,
    input  logic [PC_W-1:0] dec_pc_plus2,
    input  logic [PC_W-1:0] rs_data,
    input  logic            br_taken,
    output logic [PC_W-1:0] pc,
    output logic            redirect,
    output logic            link_we,
    output logic [PC_W-1:0] link_addr,
    output logic            halted
`ifdef PC_ALIGN_CHK_EN
    ,
    output logic            align_err
`endif
);

    localparam logic [1:0]      c_RUN    = 2'd0;
    localparam logic [1:0]      c_SQUASH = 2'd1;
    localparam logic [1:0]      c_HALT   = 2'd2;
    localparam logic [PC_W-1:0] c_PC_INC = PC_W'(2);

    logic [1:0]      r_state;
    logic [4:0]      w_op;
    logic            w_is_br, w_is_j, w_is_jal, w_is_jr, w_is_jalr, w_is_halt;
    logic            w_take, w_is_link, w_misalign;
    logic [PC_W-1:0] w_disp8, w_disp11, w_target, w_pc_inc;

    assign w_op      = dec_instr[15:11];
    assign w_is_br   = (w_op[4:2] == 3'b011);
    assign w_is_j    = (w_op == 5'b00100);
    assign w_is_jr   = (w_op == 5'b00101);
    assign w_is_jal  = (w_op == 5'b00110);
    assign w_is_jalr = (w_op == 5'b00111);
    assign w_is_halt = (w_op == 5'b00000);

    assign w_take    = (w_is_br & br_taken) | w_is_j | w_is_jal | w_is_jr | w_is_jalr;
    assign w_is_link = w_is_jal | w_is_jalr;

    assign w_disp8  = {{(PC_W-8){dec_instr[7]}}, dec_instr[7:0]} << BR_SHIFT;
    assign w_disp11 = {{(PC_W-11){dec_instr[10]}}, dec_instr[10:0]} << BR_SHIFT;

    always_comb begin
        w_target = dec_pc_plus2 + w_disp11;
        if (w_is_jr || w_is_jalr) begin
            w_target = rs_data + w_disp8;
        end else if (w_is_br) begin
            w_target = dec_pc_plus2 + w_disp8;
        end
    end

    assign w_pc_inc = pc + c_PC_INC;

`ifdef PC_ALIGN_CHK_EN
    assign w_misalign = w_target[0];
`else
    assign w_misalign = 1'b0;
`endif

    // redirect and link_we default low each cycle so they can only ever pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_RUN;
            pc        <= RESET_PC;
            redirect  <= 1'b0;
            link_we   <= 1'b0;
            link_addr <= '0;
            halted    <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
            align_err <= 1'b0;
`endif
        end else begin
            redirect <= 1'b0;
            link_we  <= 1'b0;
            case (r_state)
                c_RUN: begin
                    if (!stall) begin
                        if (dec_valid && w_is_halt) begin
                            halted  <= 1'b1;
                            r_state <= c_HALT;
                        end else if (dec_valid && w_take && w_misalign) begin
                            pc      <= w_pc_inc;
                            halted  <= 1'b1;
                            r_state <= c_HALT;
`ifdef PC_ALIGN_CHK_EN
                            align_err <= 1'b1;
`endif
                        end else if (dec_valid && w_take) begin
                            pc       <= w_target;
                            redirect <= 1'b1;
                            r_state  <= c_SQUASH;
                            if (w_is_link) begin
                                link_we   <= 1'b1;
                                link_addr <= dec_pc_plus2;
                            end
                        end else begin
                            pc <= w_pc_inc;
                        end
                    end
                end
                // The slot after a redirect holds a wrong-path instruction.
                c_SQUASH: begin
                    if (!stall) begin
                        pc      <= w_pc_inc;
                        r_state <= c_RUN;
                    end
                end
                c_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    r_state <= c_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_next_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_ctrl
// Purpose  : Vector table, hand sequences and randomized reference-model
//            checking for pc_next_ctrl (PC_W=16, RESET_PC=0, BR_SHIFT=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_ctrl;

    localparam int TB_SHIFT = 0;
    localparam int MASK     = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n, stall, dec_valid, br_taken;
    logic [15:0] dec_instr, dec_pc_plus2, rs_data;
    logic [15:0] pc, link_addr;
    logic        redirect, link_we, halted;
`ifdef PC_ALIGN_CHK_EN
    logic        align_err;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    // reference model state
    int m_pc, m_laddr;
    bit m_sq, m_halt, m_redir, m_lwe, m_align;

    typedef struct {
        logic        stall, dv;
        logic [15:0] instr, pc2, rs;
        logic        br;
        int          e_pc;
        logic        e_redir, e_lwe;
        int          e_laddr;
        logic        e_halt;
    } vec_t;
    vec_t vq[$];

    pc_next_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .BR_SHIFT(TB_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc_plus2(dec_pc_plus2), .rs_data(rs_data),
        .br_taken(br_taken), .pc(pc), .redirect(redirect), .link_we(link_we),
        .link_addr(link_addr), .halted(halted)
`ifdef PC_ALIGN_CHK_EN
        , .align_err(align_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_pc, input bit e_redir,
                           input bit e_lwe, input int e_laddr, input bit e_halt);
        chk({tag, ".pc"},        int'(pc),        e_pc);
        chk({tag, ".redirect"},  int'(redirect),  int'(e_redir));
        chk({tag, ".link_we"},   int'(link_we),   int'(e_lwe));
        chk({tag, ".link_addr"}, int'(link_addr), e_laddr);
        chk({tag, ".halted"},    int'(halted),    int'(e_halt));
    endtask

    task automatic drive(input bit s, input bit dv, input logic [15:0] ins,
                         input logic [15:0] pc2, input logic [15:0] rs, input bit br);
        stall = s; dec_valid = dv; dec_instr = ins;
        dec_pc_plus2 = pc2; rs_data = rs; br_taken = br;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #3 chk_all("reset", 0, 0, 0, 0, 0);
`ifdef PC_ALIGN_CHK_EN
        chk("reset.align_err", int'(align_err), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 0; m_laddr = 0; m_sq = 0; m_halt = 0;
        m_redir = 0; m_lwe = 0; m_align = 0;
    endtask

    function automatic int sext(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    // Behavioural next-state model built directly from the opcode rules.
    task automatic model_step(input bit s, input bit dv, input logic [15:0] ins,
                              input logic [15:0] pc2, input logic [15:0] rs, input bit br);
        int op, d8, d11, tgt;
        bit take, lnk;
        m_redir = 0; m_lwe = 0;
        if (m_halt) return;
        if (m_sq) begin
            if (!s) begin m_pc = (m_pc + 2) & MASK; m_sq = 0; end
            return;
        end
        if (s) return;
        op   = int'(ins[15:11]);
        d8   = sext(int'(ins[7:0]), 8) * (1 << TB_SHIFT);
        d11  = sext(int'(ins[10:0]), 11) * (1 << TB_SHIFT);
        take = 0; lnk = 0; tgt = 0;
        if (op >= 12 && op <= 15) begin take = br; tgt = int'(pc2) + d8; end
        else if (op == 4 || op == 6) begin take = 1; lnk = (op == 6); tgt = int'(pc2) + d11; end
        else if (op == 5 || op == 7) begin take = 1; lnk = (op == 7); tgt = int'(rs) + d8; end
        tgt = tgt & MASK;
        if (dv && op == 0) begin
            m_halt = 1;
        end else if (dv && take) begin
`ifdef PC_ALIGN_CHK_EN
            if (tgt % 2 == 1) begin
                m_pc = (m_pc + 2) & MASK; m_align = 1; m_halt = 1;
                return;
            end
`endif
            m_pc = tgt; m_redir = 1; m_sq = 1;
            if (lnk) begin m_lwe = 1; m_laddr = int'(pc2); end
        end else begin
            m_pc = (m_pc + 2) & MASK;
        end
    endtask

    task automatic add_vec(input bit s, input bit dv, input logic [15:0] ins,
                           input logic [15:0] pc2, input logic [15:0] rs, input bit br,
                           input int e_pc, input bit e_redir, input bit e_lwe,
                           input int e_laddr, input bit e_halt);
        vec_t v;
        v.stall = s; v.dv = dv; v.instr = ins; v.pc2 = pc2; v.rs = rs; v.br = br;
        v.e_pc = e_pc; v.e_redir = e_redir; v.e_lwe = e_lwe;
        v.e_laddr = e_laddr; v.e_halt = e_halt;
        vq.push_back(v);
    endtask

    initial begin
        logic [15:0] r_ins;
        bit          r_s, r_dv, r_br;
        rst_n = 1'b0; stall = 1'b0; dec_valid = 1'b0; dec_instr = '0;
        dec_pc_plus2 = '0; rs_data = '0; br_taken = 1'b0;

        //       stall dv instr     pc2       rs        br  pc       rdr lwe laddr    halt
        add_vec(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 'h0002, 0, 0, 'h0000, 0);
        add_vec(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 'h0004, 0, 0, 'h0000, 0);
        add_vec(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 'h0006, 0, 0, 'h0000, 0);
        add_vec(0, 1, 16'h6004, 16'h0010, 16'h0000, 1, 'h0014, 1, 0, 'h0000, 0);
        add_vec(0, 1, 16'h2000, 16'h0016, 16'h0000, 0, 'h0016, 0, 0, 'h0000, 0);
        add_vec(0, 1, 16'h6004, 16'h0010, 16'h0000, 0, 'h0018, 0, 0, 'h0000, 0);
        add_vec(0, 1, 16'h37FC, 16'h0100, 16'h0000, 0, 'h00FC, 1, 1, 'h0100, 0);
        add_vec(0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 'h00FE, 0, 0, 'h0100, 0);
        add_vec(1, 1, 16'h2802, 16'h0100, 16'h2000, 0, 'h00FE, 0, 0, 'h0100, 0);
        add_vec(1, 1, 16'h2802, 16'h0100, 16'h2000, 0, 'h00FE, 0, 0, 'h0100, 0);
        add_vec(1, 1, 16'h2802, 16'h0100, 16'h2000, 0, 'h00FE, 0, 0, 'h0100, 0);
        add_vec(0, 1, 16'h2802, 16'h0100, 16'h2000, 0, 'h2002, 1, 0, 'h0100, 0);
        add_vec(1, 1, 16'h2000, 16'h0000, 16'h0000, 0, 'h2002, 0, 0, 'h0100, 0);
        add_vec(0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 'h2004, 0, 0, 'h0100, 0);
        add_vec(0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 'h2004, 0, 0, 'h0100, 1);

        do_reset();
        foreach (vq[i]) begin
            drive(vq[i].stall, vq[i].dv, vq[i].instr, vq[i].pc2, vq[i].rs, vq[i].br);
            chk_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_redir,
                    vq[i].e_lwe, vq[i].e_laddr, vq[i].e_halt);
        end

        // Halted core ignores everything, including jumps and stalls.
        for (int k = 0; k < 10; k++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 16'h3000 | 16'($urandom_range(0, 2047)),
                  16'($urandom), 16'($urandom), 1'b1);
            chk_all("halt_hold", 'h2004, 0, 0, 'h0100, 1);
        end

        // Reset taken while in SQUASH must come back in RUN.
        do_reset();
        drive(0, 1, 16'h2000, 16'h0040, 16'h0000, 0);
        chk_all("pre_sq_jump", 'h0040, 1, 0, 0, 0);
        do_reset();
        drive(0, 1, 16'h2004, 16'h0080, 16'h0000, 0);
        chk_all("post_sq_jump", 'h0084, 1, 0, 0, 0);

`ifdef PC_ALIGN_CHK_EN
        do_reset();
        drive(0, 1, 16'h2801, 16'h0000, 16'h2000, 0);
        chk_all("align", 'h0002, 0, 0, 0, 1);
        chk("align.align_err", int'(align_err), 1);
`endif

        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (m_halt && $urandom_range(0, 7) == 0) do_reset();
            r_s  = ($urandom_range(0, 3) == 0);
            r_dv = ($urandom_range(0, 3) != 0);
            r_br = 1'($urandom_range(0, 1));
            r_ins = 16'($urandom);
            if ($urandom_range(0, 99) == 0) r_ins = 16'h0000;
            else if (r_ins[15:11] == 5'b00000) r_ins[15:11] = 5'b01100;
            dec_pc_plus2 = 16'($urandom);
            rs_data      = 16'($urandom);
            model_step(r_s, r_dv, r_ins, dec_pc_plus2, rs_data, r_br);
            drive(r_s, r_dv, r_ins, dec_pc_plus2, rs_data, r_br);
            chk_all("rand", m_pc, m_redir, m_lwe, m_laddr, m_halt);
`ifdef PC_ALIGN_CHK_EN
            chk("rand.align_err", int'(align_err), int'(m_align));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
